pixel_req_arbiter: RTL and testbench

Round-robin arbiter that shares the single frame-buffer pixel read port between up to N_REQ circle-code decoder instances. Each decoder presents a (location_x, location_y) request with a level handshake. The arbiter serialises requests, converts coordinates to a linear frame-buffer address and issues one read. It returns the 1-bit pixel to the granted decoder as a one-cycle answer pulse. It sits between the decoder array and the SDRAM read front-end.

---
 rtl/pixel_req_arbiter.sv | 127 ++++++++++++
 tb/tb_pixel_req_arbiter.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/pixel_req_arbiter.sv
// pixel_req_arbiter: round-robin share of the frame-buffer pixel read port among N_REQ decoders.
// Optional read timeout is built only when ARB_TIMEOUT_EN is defined.
module pixel_req_arbiter #(
  parameter int N_REQ       = 4,
  parameter int LINE_W      = 640,
  parameter int N_LINES     = 480,
  parameter int ADDR_W      = 20,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N_REQ-1:0]     pt_req,
  input  logic [N_REQ*10-1:0]  location_x,
  input  logic [N_REQ*10-1:0]  location_y,
  output logic [N_REQ-1:0]     ans_valid,
  output logic                 pixl_value,
  output logic                 rd_req,
  output logic [ADDR_W-1:0]    rd_addr,
  input  logic                 rd_ack,
  input  logic                 rd_valid,
  input  logic                 rd_data,
  output logic [2:0]           grant_id,
  output logic                 busy,
  output logic                 timeout_err
);
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_GRANT = 3'd1;
  localparam logic [2:0] S_ISSUE = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;
  logic [2:0]        r_state, r_grant, r_last;
  logic [9:0]        r_x, r_y;
  logic              r_pix;
  logic [2:0]        w_win;
  logic [9:0]        w_x, w_y;
  logic [3:0]        w_d, w_best;
  logic [ADDR_W-1:0] w_lin;
  logic              w_oor, w_to;
  // Lowest rotated distance from last_grant+1 wins.
  always_comb begin
    w_win  = r_last;
    w_x    = '0;
    w_y    = '0;
    w_d    = '0;
    w_best = 4'hF;
    for (int i = 0; i < N_REQ; i++) begin
      w_d = 4'(i + N_REQ - 1) - {1'b0, r_last};
      w_d = (w_d >= 4'(N_REQ)) ? w_d - 4'(N_REQ) : w_d;
      if (pt_req[i] && w_d < w_best) begin
        w_best = w_d;
        w_win  = 3'(i);
        w_x    = location_x[10*i +: 10];
        w_y    = location_y[10*i +: 10];
      end
    end
  end
  assign w_lin = ADDR_W'(32'(r_y) * 32'(LINE_W) + 32'(r_x));
  assign w_oor = (32'(r_x) >= 32'(LINE_W)) || (32'(r_y) >= 32'(N_LINES));
`ifdef ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  logic [CW-1:0] r_cnt;
  logic          r_to;
  logic          w_rd_phase;
  assign w_rd_phase  = (r_state == S_ISSUE) || (r_state == S_WAIT);
  assign w_to        = w_rd_phase && (32'(r_cnt) >= 32'(TIMEOUT_CYC - 1));
  assign timeout_err = (r_state == S_DONE) && r_to;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_to  <= 1'b0;
    end else begin
      r_cnt <= (r_state == S_GRANT) ? '0 : w_rd_phase ? r_cnt + CW'(1) : r_cnt;
      r_to  <= w_to;
    end
  end
`else
  assign w_to        = 1'b0;
  assign timeout_err = 1'b0;
`endif
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_grant <= '0;
      r_last  <= 3'(N_REQ - 1);
      r_x     <= '0;
      r_y     <= '0;
      r_pix   <= 1'b0;
      rd_addr <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (|pt_req) begin
          r_state <= S_GRANT;
          r_grant <= w_win;
          r_x     <= w_x;
          r_y     <= w_y;
        end
        S_GRANT: begin
          rd_addr <= w_lin;
          r_pix   <= 1'b0;
          r_state <= w_oor ? S_DONE : S_ISSUE;
        end
        S_ISSUE: if (w_to) begin
          r_state <= S_DONE;
        end else if (rd_ack) begin
          r_pix   <= rd_valid ? rd_data : r_pix;
          r_state <= rd_valid ? S_DONE : S_WAIT;
        end
        S_WAIT: if (w_to) begin
          r_state <= S_DONE;
        end else if (rd_valid) begin
          r_pix   <= rd_data;
          r_state <= S_DONE;
        end
        S_DONE: begin
          r_last  <= r_grant;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
  assign rd_req     = r_state == S_ISSUE;
  assign busy       = r_state != S_IDLE;
  assign grant_id   = r_grant;
  assign pixl_value = (r_state == S_DONE) && r_pix;
  assign ans_valid  = (r_state == S_DONE) ? N_REQ'(1) << r_grant : '0;
endmodule

// File: tb/tb_pixel_req_arbiter.sv
// tb_pixel_req_arbiter: vector table plus corner sequences, answers checked through a scoreboard queue.
module tb_pixel_req_arbiter;
  logic        clk = 0, rst_n = 0;
  logic [3:0]  pt_req = 0;
  logic [39:0] location_x = 0, location_y = 0;
  logic [3:0]  ans_valid;
  logic        pixl_value, rd_req, busy, timeout_err;
  logic [19:0] rd_addr;
  logic        rd_ack = 0, rd_valid = 0, rd_data = 0;
  logic [2:0]  grant_id;

  pixel_req_arbiter dut (
    .clk(clk), .rst_n(rst_n), .pt_req(pt_req), .location_x(location_x), .location_y(location_y),
    .ans_valid(ans_valid), .pixl_value(pixl_value), .rd_req(rd_req), .rd_addr(rd_addr),
    .rd_ack(rd_ack), .rd_valid(rd_valid), .rd_data(rd_data), .grant_id(grant_id),
    .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {logic [3:0] ans; logic pix; int cyc; logic to;} exp_t;
  typedef struct {int id; int x; int y; int ack; int val; logic d; int addr; logic oor; int lat; logic [3:0] ans; logic pix;} vec_t;
  exp_t q[$];
  vec_t tbl[7];
  int checks = 0, passes = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
  endtask

  // memory model: ack after ack_dly ISSUE cycles, data val_dly cycles later
  int   ack_dly = 0, val_dly = 1, issue_n = 0, post = 0;
  logic mem_d = 1;
  bit   acked = 0;
  initial forever begin
    @(negedge clk);
    rd_ack = 0;
    rd_valid = 0;
    if (!rst_n) begin
      issue_n = 0;
      acked = 0;
    end else if (acked) begin
      post++;
      if (post >= val_dly) begin rd_valid = 1; acked = 0; end
    end else if (rd_req) begin
      if (issue_n >= ack_dly) begin
        rd_ack = 1;
        issue_n = 0;
        if (val_dly == 0) rd_valid = 1;
        else begin acked = 1; post = 0; end
      end else issue_n++;
    end else issue_n = 0;
    rd_data = rd_valid ? mem_d : ~mem_d;
  end

  bit          chk_addr = 0, saw_req = 0, drop = 0, prev_req = 0;
  int          exp_addr = 0, rq_cnt = 0;
  logic [19:0] prev_addr = 0;
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (rd_req) begin
          saw_req = 1;
          rq_cnt++;
          if (!prev_req && chk_addr) chk("rd_addr", rd_addr, exp_addr);
          if (prev_req) chk("rd_addr_stable", rd_addr, prev_addr);
        end
        if (ans_valid != 0) begin
          if (q.size() == 0) chk("unexpected_ans", ans_valid, 0);
          else begin
            e = q.pop_front();
            chk("ans_id", ans_valid, e.ans);
            chk("pixl_value", pixl_value, e.pix);
            chk("ans_cycle", cyc, e.cyc);
            chk("timeout_err", timeout_err, e.to);
          end
          if (drop) pt_req = pt_req & ~ans_valid;
        end
      end
      prev_req = rd_req;
      prev_addr = rd_addr;
    end
  end

  task automatic req(input int id, input int x, input int y);
    pt_req[id] = 1;
    location_x[10*id +: 10] = 10'(x);
    location_y[10*id +: 10] = 10'(y);
  endtask

  task automatic wait_q(input int budget);
    int n = 0;
    while (q.size() != 0 && n < budget) begin @(negedge clk); n++; end
    if (q.size() != 0) begin chk("answer_budget", q.size(), 0); q.delete(); end
  endtask

  task automatic chk_reset_outs();
    chk("rst_ans_valid", ans_valid, 0);
    chk("rst_pixl_value", pixl_value, 0);
    chk("rst_rd_req", rd_req, 0);
    chk("rst_rd_addr", rd_addr, 0);
    chk("rst_grant_id", grant_id, 0);
    chk("rst_busy", busy, 0);
    chk("rst_timeout_err", timeout_err, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int t0;
    tbl[0] = '{2, 10, 3, 0, 1, 1'b1, 1930, 1'b0, 4, 4'b0100, 1'b1};
    tbl[1] = '{0, 640, 5, 0, 1, 1'b1, 0, 1'b1, 2, 4'b0001, 1'b0};
    tbl[2] = '{1, 0, 0, 0, 0, 1'b0, 0, 1'b0, 3, 4'b0010, 1'b0};
    tbl[3] = '{3, 639, 479, 6, 3, 1'b1, 307199, 1'b0, 12, 4'b1000, 1'b1};
    tbl[4] = '{1, 5, 480, 0, 1, 1'b1, 0, 1'b1, 2, 4'b0010, 1'b0};
    tbl[5] = '{2, 1023, 0, 0, 1, 1'b1, 0, 1'b1, 2, 4'b0100, 1'b0};
    tbl[6] = '{0, 100, 200, 2, 1, 1'b1, 128100, 1'b0, 6, 4'b0001, 1'b1};
    repeat (2) @(negedge clk);
    chk_reset_outs();
    rst_n = 1;
    @(negedge clk);
    // contention after reset: order 0,1,2,3, five cycles apart
    ack_dly = 0; val_dly = 1; mem_d = 1; chk_addr = 0; drop = 1;
    for (int i = 0; i < 4; i++) req(i, 10 * i, i);
    t0 = cyc;
    for (int i = 0; i < 4; i++) q.push_back('{4'(1 << i), 1'b1, t0 + 4 + 5 * i, 1'b0});
    wait_q(60);
    repeat (2) @(negedge clk);
    drop = 0;
    pt_req = 0;
    // fairness: 1 and 3 keep requesting
    req(1, 4, 4); req(3, 6, 6);
    t0 = cyc;
    for (int i = 0; i < 4; i++) q.push_back('{(i % 2 == 0) ? 4'b0010 : 4'b1000, 1'b1, t0 + 4 + 5 * i, 1'b0});
    wait_q(60);
    pt_req = 0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 7; i++) begin
      ack_dly = tbl[i].ack; val_dly = tbl[i].val; mem_d = tbl[i].d;
      exp_addr = tbl[i].addr; chk_addr = !tbl[i].oor; saw_req = 0;
      req(tbl[i].id, tbl[i].x, tbl[i].y);
      q.push_back('{tbl[i].ans, tbl[i].pix, cyc + tbl[i].lat, 1'b0});
      repeat (tbl[i].lat) begin @(negedge clk); chk("busy", busy, 1); end
      pt_req = 0;
      @(negedge clk);
      chk("busy_idle", busy, 0);
      chk("answered", q.size(), 0);
      chk("rd_req_issued", saw_req, !tbl[i].oor);
      if (q.size() != 0) wait_q(50);
    end
    // reset in the middle of WAIT
    ack_dly = 0; val_dly = 100000; chk_addr = 0;
    req(1, 20, 20);
    repeat (5) @(negedge clk);
    chk("wait_busy", busy, 1);
    chk("wait_rd_req", rd_req, 0);
    #1 rst_n = 0;
    pt_req = 0;
    #1 chk_reset_outs();
    repeat (2) @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    val_dly = 1; mem_d = 1; drop = 1;
    req(0, 7, 2); req(3, 8, 2);
    t0 = cyc;
    q.push_back('{4'b0001, 1'b1, t0 + 4, 1'b0});
    q.push_back('{4'b1000, 1'b1, t0 + 9, 1'b0});
    wait_q(40);
    repeat (2) @(negedge clk);
    pt_req = 0;
`ifdef ARB_TIMEOUT_EN
    ack_dly = 1000000; rq_cnt = 0;
    req(2, 1, 1);
    q.push_back('{4'b0100, 1'b0, cyc + 257, 1'b1});
    wait_q(400);
    @(negedge clk);
    chk("timeout_rd_req_cycles", rq_cnt, 255);
    pt_req = 0;
    ack_dly = 0;
`endif
    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
